alu_entry_ctrl: RTL and testbench
=================================

Name: alu_entry_ctrl

Overview:
- Sequential operand/opcode entry stage and ALU directly upstream of the 3-digit display driver.
- User sets 3 slide switches and presses one ENTER button three times: operand A, operand B, opcode.
- Block computes and holds a 6-bit two's-complement result plus the 3-bit opcode, driving the display driver's result and opcodesel inputs.
- Handles button debounce and edge detection internally.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive clk_in cycles btn must be stable before the debounced level changes (minimum 2).
- CNT_W, 18, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk_in  input  1  system clock, single domain
- reset_n  input  1  asynchronous active-low reset
- sw  input  3  switch data, captured as operand or opcode
- btn  input  1  raw ENTER push button, active-high, asynchronous and bouncy
- result  output  6  registered ALU result, two's complement
- opcodesel  output  3  registered opcode, to display driver
- stage  output  2  current FSM state encoding, for LEDs
- result_valid  output  1  high while result reflects a completed operation

Behaviour:
- Reset (async, reset_n=0): state=LOAD_A; opA, opB, opcodesel=3'b000; result=6'd0; result_valid=0; debounce counter=0; btn_clean=0.
- Debounce:
  - btn_s is btn (see optional feature).
  - If btn_s != btn_clean, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 with btn_s still different, btn_clean<=btn_s and the counter clears.
- press: one-cycle pulse, btn_clean & ~btn_clean_d (btn_clean_d is btn_clean delayed one cycle). Release generates no press.
- FSM states and stage encoding: LOAD_A=00, LOAD_B=01, LOAD_OP=10, SHOW=11. Transitions occur only on press:
  - LOAD_A: opA<=sw; result_valid<=0; go to LOAD_B. result holds its old value.
  - LOAD_B: opB<=sw; go to LOAD_OP.
  - LOAD_OP: opcodesel<=sw; result<=f(opA, opB, sw) on the same edge; result_valid<=1; go to SHOW.
  - SHOW: go to LOAD_A. No register changes except result_valid<=0.
- Without press, all state and registers hold.
- Operands are 3-bit signed, range -4..+3.
- ALU f, all results 6 bits:
  - 000 ADD: sign-extended A+B, range -8..6.
  - 001 SUB: A-B, range -7..7.
  - 010 MUL: signed A*B, range -12..16. Never overflows 6 bits.
  - 011 AND, 100 OR, 101 XOR: 3-bit bitwise, zero-extended to 6 bits.
  - 110 XNOR: 3-bit bitwise XNOR, zero-extended. The display driver shows result[2:0] in binary for this opcode.
  - 111 NEG: -A, sign-extended; B ignored; range -3..4.
- Latency: result and opcodesel update on the clock edge where press=1 in LOAD_OP; visible the following cycle.
- Boundary conditions:
  - sw changes while no press: no effect.
  - Bounce shorter than DEBOUNCE_CYCLES: no press.
  - Button held indefinitely: exactly one press.
  - reset_n asserted mid-entry: immediate return to LOAD_A with all registers cleared; partial operands are discarded.
  - reset_n release does not generate a press even if btn is held, because btn_clean starts at 0 and must first debounce high.
    - Correction, decided: a held button after reset does produce one press after DEBOUNCE_CYCLES; this is acceptable and must be tested.

Optional Feature:
- Macro: ALU_BTN_SYNC_EN.
- Defined: btn passes through a two-flop synchronizer (both flops reset to 0) before the debouncer. press occurs 2 cycles later than without the macro.
- Undefined: btn_s = btn directly; the caller guarantees external synchronization.
- sw is never synchronized; it is sampled only on press.

Test Plan:
- Reset then idle: result=0, opcodesel=000, stage=00, result_valid=0; hold for 100 cycles with btn=0, nothing changes.
- DEBOUNCE_CYCLES=4. Enter sw=011, 010, 000 with clean presses -> stage 00->01->10->11, result=6'd5, opcodesel=000, result_valid=1.
- Enter A=100 (-4), B=100 (-4), op=010 -> result=6'b010000 (16). Enter A=011, B=100, op=001 -> result=6'd7. Enter A=001, op=111 -> result=6'b111111 (-1).
- Enter A=101, B=011, op=110 -> result=6'b000001, opcodesel=110.
- Bounce: toggle btn every 2 cycles for 20 cycles, then hold high 10 cycles -> exactly one stage advance. Holding btn high 1000 cycles -> exactly one advance.
- Assert reset_n low in stage 10 after A=011, B=011 -> stage=00, result=0 immediately. Then enter 001, 001, op=000 -> result=2.

Source files
------------

// File: rtl/alu_entry_ctrl_if.sv
// Bus between the ENTER/switch front panel and alu_entry_ctrl.
// The panel side (master) drives the switches and the raw button. The block
// side (slave) returns the held result, opcode, stage and valid flag.
interface alu_entry_ctrl_if;
    logic [2:0] sw;
    logic       btn;
    logic [5:0] result;
    logic [2:0] opcodesel;
    logic [1:0] stage;
    logic       result_valid;

    modport master (
        output sw, btn,
        input  result, opcodesel, stage, result_valid
    );

    modport slave (
        input  sw, btn,
        output result, opcodesel, stage, result_valid
    );
endinterface

// File: rtl/alu_entry_ctrl.sv
// alu_entry_ctrl: three-press operand/opcode entry stage with a small signed ALU.
// A press on ENTER loads operand A, then operand B, then the opcode, which also
// computes and holds the 6-bit two's-complement result for the display driver.
// Optional macro ALU_BTN_SYNC_EN inserts a two-flop synchronizer on btn ahead of
// the debouncer; without it btn must already be synchronous to clk_in.
module alu_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18
) (
    input  logic             clk_in,
    input  logic             reset_n,
    alu_entry_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        SHOW    = 2'b11
    } state_t;

    // Operands are sign-extended before arithmetic; bitwise ops stay 3-bit and
    // are zero-extended so the display can show them as a plain binary pattern.
    function automatic logic [5:0] alu_f(
        input logic signed [2:0] a,
        input logic signed [2:0] b,
        input logic        [2:0] op
    );
        logic signed [5:0] ea;
        logic signed [5:0] eb;
        ea = {{3{a[2]}}, a};
        eb = {{3{b[2]}}, b};
        case (op)
            3'b000:  alu_f = ea + eb;
            3'b001:  alu_f = ea - eb;
            3'b010:  alu_f = ea * eb;
            3'b011:  alu_f = {3'b000, a & b};
            3'b100:  alu_f = {3'b000, a | b};
            3'b101:  alu_f = {3'b000, a ^ b};
            3'b110:  alu_f = {3'b000, ~(a ^ b)};
            default: alu_f = -ea;
        endcase
    endfunction

    logic             w_btn_s;
    logic [CNT_W-1:0] r_cnt;
    logic             r_btn_clean;
    logic             r_btn_clean_d;
    logic             w_press;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_opa;
    logic [2:0]       w_opa_nxt;
    logic [2:0]       r_opb;
    logic [2:0]       w_opb_nxt;
    logic [2:0]       r_opcode;
    logic [2:0]       w_opcode_nxt;
    logic [5:0]       r_result;
    logic [5:0]       w_result_nxt;
    logic             r_valid;
    logic             w_valid_nxt;

`ifdef ALU_BTN_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer bringing the asynchronous button into clk_in.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_s = r_sync2;
`else
    assign w_btn_s = bus.btn;
`endif

    // Debouncer: the clean level follows btn_s only after it has differed for
    // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt       <= '0;
            r_btn_clean <= 1'b0;
        end else if (w_btn_s != r_btn_clean) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_btn_clean <= w_btn_s;
                r_cnt       <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // Delayed clean level for rising-edge detection; release makes no press.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) r_btn_clean_d <= 1'b0;
        else          r_btn_clean_d <= r_btn_clean;
    end

    assign w_press = r_btn_clean & ~r_btn_clean_d;

    // Entry FSM next state and register loads; everything holds without a press.
    always_comb begin
        w_state_nxt  = r_state;
        w_opa_nxt    = r_opa;
        w_opb_nxt    = r_opb;
        w_opcode_nxt = r_opcode;
        w_result_nxt = r_result;
        w_valid_nxt  = r_valid;
        if (w_press) begin
            case (r_state)
                LOAD_A: begin
                    w_opa_nxt   = bus.sw;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = LOAD_B;
                end
                LOAD_B: begin
                    w_opb_nxt   = bus.sw;
                    w_state_nxt = LOAD_OP;
                end
                LOAD_OP: begin
                    w_opcode_nxt = bus.sw;
                    w_result_nxt = alu_f(r_opa, r_opb, bus.sw);
                    w_valid_nxt  = 1'b1;
                    w_state_nxt  = SHOW;
                end
                default: begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = LOAD_A;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards any partial entry.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= LOAD_A;
            r_opa    <= 3'b000;
            r_opb    <= 3'b000;
            r_opcode <= 3'b000;
            r_result <= 6'd0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_opa    <= w_opa_nxt;
            r_opb    <= w_opb_nxt;
            r_opcode <= w_opcode_nxt;
            r_result <= w_result_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    assign bus.result       = r_result;
    assign bus.opcodesel    = r_opcode;
    assign bus.stage        = r_state;
    assign bus.result_valid = r_valid;

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Self-checking bench for alu_entry_ctrl with a short debounce window.
module tb_alu_entry_ctrl;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference state kept as plain integers.
    int m_stage;
    int m_a;
    int m_b;
    int m_op;
    int m_res;
    int m_vld;

    alu_entry_ctrl_if bus ();

    alu_entry_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
        .clk_in  (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic int sx3(input int v);
        return (v >= 4) ? v - 8 : v;
    endfunction

    function automatic int ref_alu(input int a, input int b, input int op);
        int sa;
        int sb;
        int r;
        sa = sx3(a);
        sb = sx3(b);
        case (op)
            0: r = sa + sb;
            1: r = sa - sb;
            2: r = sa * sb;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = (~(a ^ b)) & 7;
            default: r = -sa;
        endcase
        return r & 63;
    endfunction

    task automatic model_reset();
        m_stage = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_vld = 0;
    endtask

    task automatic model_press(input int swv);
        case (m_stage)
            0: begin m_a = swv; m_vld = 0; end
            1: m_b = swv;
            2: begin m_op = swv; m_res = ref_alu(m_a, m_b, swv); m_vld = 1; end
            default: m_vld = 0;
        endcase
        m_stage = (m_stage + 1) % 4;
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".result"}, int'(bus.result), m_res);
        check({tag, ".opcodesel"}, int'(bus.opcodesel), m_op);
        check({tag, ".stage"}, int'(bus.stage), m_stage);
        check({tag, ".valid"}, int'(bus.result_valid), m_vld);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: hold long enough to debounce, release, scramble sw.
    task automatic press(input int swv, input string tag);
        bus.sw  = 3'(swv);
        bus.btn = 1'b1;
        cyc(1);
        check({tag, ".early"}, int'(bus.stage), m_stage);
        cyc(9);
        bus.btn = 1'b0;
        cyc(2);
        bus.sw = 3'($urandom_range(0, 7));
        cyc(8);
        model_press(swv);
        check_all(tag);
    endtask

    initial begin
        bus.sw  = 3'b000;
        bus.btn = 1'b0;
        model_reset();
        cyc(3);
        check_all("reset");
        rst_n = 1'b1;
        cyc(100);
        check_all("idle100");

        // Directed entries
        press(3, "d1a"); press(2, "d1b"); press(0, "d1op");
        check("add_5", int'(bus.result), 5);
        press(0, "d1show");
        press(4, "d2a"); press(4, "d2b"); press(2, "d2op");
        check("mul_16", int'(bus.result), 16);
        press(0, "d2show");
        press(3, "d3a"); press(4, "d3b"); press(1, "d3op");
        check("sub_7", int'(bus.result), 7);
        press(0, "d3show");
        press(1, "d4a"); press(6, "d4b"); press(7, "d4op");
        check("neg_m1", int'(bus.result), 63);
        press(0, "d4show");
        press(5, "d5a"); press(3, "d5b"); press(6, "d5op");
        check("xnor_1", int'(bus.result), 1);
        check("xnor_op", int'(bus.opcodesel), 6);
        press(0, "d5show");

        // sw activity without a press
        for (int i = 0; i < 10; i++) begin
            bus.sw = 3'($urandom_range(0, 7));
            cyc(3);
        end
        check_all("sw_nopress");

        // Bounce shorter than the debounce window, then a real hold
        bus.sw = 3'b010;
        for (int i = 0; i < 10; i++) begin
            bus.btn = ~bus.btn;
            cyc(2);
        end
        check_all("bounce_only");
        bus.btn = 1'b1;
        cyc(10);
        bus.btn = 1'b0;
        cyc(10);
        model_press(2);
        check_all("bounce_then_hold");

        // Held button: one advance only
        bus.sw  = 3'b001;
        bus.btn = 1'b1;
        cyc(1000);
        bus.btn = 1'b0;
        cyc(10);
        model_press(1);
        check_all("hold1000");

        // Finish the current entry to reach LOAD_A
        while (m_stage != 0) press(0, "align");

        // Reset mid-entry
        press(3, "r_a"); press(3, "r_b");
        check("r_stage10", int'(bus.stage), 2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_mid");
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        press(1, "p_a"); press(1, "p_b"); press(0, "p_op");
        check("post_reset_2", int'(bus.result), 2);
        press(0, "p_show");

        // Button held through reset release produces exactly one press
        bus.sw  = 3'b101;
        bus.btn = 1'b1;
        cyc(3);
        rst_n = 1'b0;
        cyc(2);
        model_reset();
        check_all("held_in_reset");
        rst_n = 1'b1;
        cyc(30);
        model_press(5);
        check_all("held_after_reset");
        bus.btn = 1'b0;
        cyc(10);
        check_all("held_release");

        // Randomized full entries
        for (int k = 0; k < 12; k++) begin
            press(int'($urandom_range(0, 7)), "rnd_a");
            press(int'($urandom_range(0, 7)), "rnd_b");
            press(int'($urandom_range(0, 7)), "rnd_op");
            press(int'($urandom_range(0, 7)), "rnd_show");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
